rsa_mux_sched: RTL and testbench

Sequencer for a bank of RSA_LANES registered 2:1 input muxes feeding the systolic array (RSA) edge.
- Accepts one command per transfer: source select plus beat count.
- Drives per-lane mux enable and select with a diagonal skew of one cycle per lane, so data enters the array as a wavefront.
- Signals completion once the last lane has finished.

---
 rtl/rsa_sched_pkg.sv | 17 +
 rtl/rsa_skew_line.sv | 56 +++++
 rtl/rsa_mux_sched.sv | 164 ++++++++++++++++
 tb/tb_rsa_mux_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rsa_sched_pkg.sv
// Shared definitions for the RSA edge mux sequencer.
//   sched_state_t  : sequencer state encoding (IDLE, ZERO, FEED, DRAIN)
//   RSA_LANES_DEF  : default number of mux lanes / array rows
//   LEN_W_DEF      : default width of the beat-count field
package rsa_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ZERO  = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    localparam int RSA_LANES_DEF = 4;
    localparam int LEN_W_DEF     = 8;

endpackage

// File: rtl/rsa_skew_line.sv
// Diagonal skew line: an LANES-1 stage shift register that carries lane 0's
// {en, sel} pair to lanes 1..LANES-1, one clock of delay per lane.
// Ports:
//   clk      : clock
//   sys_rst  : synchronous active-high reset, clears every stage
//   clr      : synchronous clear (used to flush an aborted transfer)
//   en_in    : lane-0 enable
//   sel_in   : lane-0 select
//   en_out   : enables for lanes 1..LANES-1 (bit i = lane i+1)
//   sel_out  : selects for lanes 1..LANES-1 (bit i = lane i+1)
module rsa_skew_line #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             en_in,
    input  logic             sel_in,
    output logic [LANES-2:0] en_out,
    output logic [LANES-2:0] sel_out
);

    logic en_stage_reg  [LANES-1];
    logic sel_stage_reg [LANES-1];

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_stage
            logic en_prev;
            logic sel_prev;

            // Stage 0 takes lane 0 directly; later stages take their neighbour.
            if (gi == 0) begin : g_head
                assign en_prev  = en_in;
                assign sel_prev = sel_in;
            end else begin : g_body
                assign en_prev  = en_stage_reg[gi-1];
                assign sel_prev = sel_stage_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (sys_rst || clr) begin
                    en_stage_reg[gi]  <= 1'b0;
                    sel_stage_reg[gi] <= 1'b0;
                end else begin
                    en_stage_reg[gi]  <= en_prev;
                    sel_stage_reg[gi] <= sel_prev;
                end
            end

            assign en_out[gi]  = en_stage_reg[gi];
            assign sel_out[gi] = sel_stage_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/rsa_mux_sched.sv
// Sequencer for a bank of RSA_LANES registered 2:1 muxes at the systolic
// array edge. One command (source + beat count) per transfer; lane k's
// enable/select is lane 0's delayed k cycles so data enters as a wavefront.
// Optional feature macro: RSA_MUX_SCHED_ABORT_EN adds abort / aborted.
// Ports:
//   clk, sys_rst         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_src, cmd_len     : source select and beats per lane (0 allowed)
//   mux_en, mux_sel      : per-lane mux enable / select (lane k = bit k)
//   busy                 : transfer in FEED or DRAIN
//   done                 : one-cycle completion pulse
//   abort, aborted       : (macro only) cancel request / one-cycle ack
module rsa_mux_sched
    import rsa_sched_pkg::*;
#(
    parameter int RSA_LANES = RSA_LANES_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_src,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic [RSA_LANES-1:0] mux_en,
    output logic [RSA_LANES-1:0] mux_sel,
    output logic                 busy,
    output logic                 done
`ifdef RSA_MUX_SCHED_ABORT_EN
    ,
    input  logic                 abort,
    output logic                 aborted
`endif
);

    // Holds RSA_LANES-1, which always fits in clog2(RSA_LANES) bits.
    localparam int DRAIN_W = $clog2(RSA_LANES);

    sched_state_t         state_reg;
    logic [LEN_W-1:0]     len_cnt_reg;
    logic [DRAIN_W-1:0]   drain_cnt_reg;
    logic                 en0_reg;
    logic                 sel0_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 ready_reg;
    logic                 abort_hit;
    logic [RSA_LANES-2:0] skew_en;
    logic [RSA_LANES-2:0] skew_sel;

`ifdef RSA_MUX_SCHED_ABORT_EN
    logic aborted_reg;

    // Abort only has an effect while a transfer is actually moving data.
    assign abort_hit = abort && ((state_reg == ST_FEED) || (state_reg == ST_DRAIN));
    assign aborted   = aborted_reg;
`else
    assign abort_hit = 1'b0;
`endif

    // ZERO is the done cycle of an empty command; like the done cycle of a
    // normal transfer it keeps cmd_ready high and may accept the next command.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            len_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            en0_reg       <= 1'b0;
            sel0_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ready_reg     <= 1'b1;
`ifdef RSA_MUX_SCHED_ABORT_EN
            aborted_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef RSA_MUX_SCHED_ABORT_EN
            aborted_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE, ST_ZERO: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            state_reg <= ST_ZERO;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ST_FEED;
                            len_cnt_reg <= cmd_len;
                            en0_reg     <= 1'b1;
                            sel0_reg    <= cmd_src;
                            busy_reg    <= 1'b1;
                            ready_reg   <= 1'b0;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                ST_FEED: begin
                    if (abort_hit) begin
                        state_reg <= ST_IDLE;
                        en0_reg   <= 1'b0;
                        sel0_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
`ifdef RSA_MUX_SCHED_ABORT_EN
                        aborted_reg <= 1'b1;
`endif
                    end else if (len_cnt_reg == LEN_W'(1)) begin
                        // Last lane-0 beat is on now; the other lanes trail it.
                        state_reg     <= ST_DRAIN;
                        en0_reg       <= 1'b0;
                        sel0_reg      <= 1'b0;
                        drain_cnt_reg <= DRAIN_W'(RSA_LANES - 1);
                    end else begin
                        len_cnt_reg <= len_cnt_reg - LEN_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (abort_hit) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
`ifdef RSA_MUX_SCHED_ABORT_EN
                        aborted_reg <= 1'b1;
`endif
                    end else if (drain_cnt_reg == DRAIN_W'(1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    rsa_skew_line #(
        .LANES (RSA_LANES)
    ) u_skew (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clr     (abort_hit),
        .en_in   (en0_reg),
        .sel_in  (sel0_reg),
        .en_out  (skew_en),
        .sel_out (skew_sel)
    );

    assign mux_en    = {skew_en, en0_reg};
    assign mux_sel   = {skew_sel, sel0_reg};
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cmd_ready = ready_reg;

endmodule

// File: tb/tb_rsa_mux_sched.sv
// Randomized bench for rsa_mux_sched. The reference model keeps expected
// output values per clock edge in arrays and fills them directly from the
// command timing rules when a command is accepted.
module tb_rsa_mux_sched;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int NC = 3000;
    localparam int SZ = NC + 300;

    logic          clk;
    logic          sys_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_src;
    logic [LW-1:0] cmd_len;
    logic [N-1:0]  mux_en;
    logic [N-1:0]  mux_sel;
    logic          busy;
    logic          done;
`ifdef RSA_MUX_SCHED_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    rsa_mux_sched #(
        .RSA_LANES (N),
        .LEN_W     (LW)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_len   (cmd_len),
        .mux_en    (mux_en),
        .mux_sel   (mux_sel),
        .busy      (busy),
        .done      (done)
`ifdef RSA_MUX_SCHED_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected value of each output right after edge e.
    logic [N-1:0] exp_en   [SZ];
    logic [N-1:0] exp_sel  [SZ];
    logic         exp_busy [SZ];
    logic         exp_done [SZ];
    logic         exp_abt  [SZ];
    int           free_edge;   // first edge after which cmd_ready is high
    int           total;
    int           bad;
    int           cur_edge;
    int           n_cmd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cur_edge, got, exp);
        end
    endtask

    task automatic clear_from(input int e0);
        for (int e = e0; e < SZ; e++) begin
            exp_en[e]   = '0;
            exp_sel[e]  = '0;
            exp_busy[e] = 1'b0;
            exp_done[e] = 1'b0;
            exp_abt[e]  = 1'b0;
        end
    endtask

    // Command accepted at edge t: lane k enabled after edges t+k..t+len-1+k,
    // busy after edges t..t+len+N-2, done after edge t+len+N-1 (t if len==0).
    task automatic schedule(input int t, input logic src, input int len);
        int d;
        if (len == 0) begin
            d = t;
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int e = t + k; e <= t + len - 1 + k; e++) begin
                    exp_en[e][k]  = 1'b1;
                    exp_sel[e][k] = src;
                end
            end
            for (int e = t; e <= t + len + N - 2; e++) exp_busy[e] = 1'b1;
            d = t + len + N - 1;
        end
        exp_done[d] = 1'b1;
        free_edge = d;
    endtask

    initial begin
        logic want_max;
        int   r;
        total     = 0;
        bad       = 0;
        n_cmd     = 0;
        free_edge = 0;
        want_max  = 1'b0;
        clear_from(0);

        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = 1'b0;
        cmd_len   = '0;
`ifdef RSA_MUX_SCHED_ABORT_EN
        abort     = 1'b0;
`endif

        for (int n = 1; n < NC; n++) begin
            // Inputs for edge n; src/len change every cycle, even when busy.
            sys_rst   = (n <= 3) || ($urandom_range(0, 299) == 0);
            if (n == 60) want_max = 1'b1;
            cmd_valid = want_max || ($urandom_range(0, 99) < 40);
            cmd_src   = 1'($urandom_range(0, 1));
            r         = $urandom_range(0, 99);
            if (want_max)   cmd_len = 8'hFF;
            else if (r < 15) cmd_len = '0;
            else if (r < 22) cmd_len = LW'($urandom_range(7, 40));
            else             cmd_len = LW'($urandom_range(1, 6));
`ifdef RSA_MUX_SCHED_ABORT_EN
            abort = ($urandom_range(0, 59) == 0);
`endif

            @(posedge clk);
            #1;
            cur_edge = n;

            if (sys_rst) begin
                clear_from(n);
                free_edge = n;
            end else if (cmd_valid && (n - 1 >= free_edge)) begin
                n_cmd++;
                $display("cmd %0d: edge=%0d src=%0d len=%0d", n_cmd, n, cmd_src, cmd_len);
                if (cmd_len == 8'hFF) want_max = 1'b0;
                schedule(n, cmd_src, int'(cmd_len));
            end
`ifdef RSA_MUX_SCHED_ABORT_EN
            else if (abort && exp_busy[n-1]) begin
                $display("abort: edge=%0d", n);
                clear_from(n);
                exp_abt[n] = 1'b1;
                free_edge  = n;
            end
`endif

            chk("mux_en",    32'(mux_en),    32'(exp_en[n]));
            chk("mux_sel",   32'(mux_sel),   32'(exp_sel[n]));
            chk("busy",      32'(busy),      32'(exp_busy[n]));
            chk("done",      32'(done),      32'(exp_done[n]));
            chk("cmd_ready", 32'(cmd_ready), 32'(n >= free_edge));
`ifdef RSA_MUX_SCHED_ABORT_EN
            chk("aborted",   32'(aborted),   32'(exp_abt[n]));
`endif

            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
